key_matrix_scan: RTL

KEY_MATRIX_SCAN -- requirements
Module: key_matrix_scan

---
 rtl/key_matrix_scan.sv | 88 ++++++++
 1 files changed

// File: rtl/key_matrix_scan.sv
// Keyboard matrix front end: synchronizes and debounces 44 switches and
// serves the CPU's column strobes with the debounced image.
module key_matrix_scan #(
  parameter int TICK_DIV         = 12000,
  parameter int DEBOUNCE_SAMPLES = 4
) (
  input  logic        raw_clk,
  input  logic        button_reset,
  input  logic [43:0] key_raw,
  input  logic [10:0] pins_r,
  output logic [3:0]  pins_k,
  output logic [43:0] key_state,
  output logic        key_any,
  output logic        key_changed
);

  localparam int NR   = 11;
  localparam int NK   = 4;
  localparam int NKEY = NR * NK;
  localparam int DS   = DEBOUNCE_SAMPLES;
  localparam int CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [NKEY-1:0]         sync1;
  logic [NKEY-1:0]         sync2;
  logic [CW-1:0]           tick_cnt;
  logic                    tick;
  logic [NKEY-1:0][DS-1:0] hist;
  logic [NKEY-1:0][DS-1:0] hist_upd;
  logic [NKEY-1:0]         state_nxt;
  logic [NK-1:0]           col_k;

  assign tick = (tick_cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge raw_clk or negedge button_reset) begin
    if (!button_reset) begin
      sync1    <= '0;
      sync2    <= '0;
      tick_cnt <= '0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      if (tick) tick_cnt <= '0;
      else      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // A key flips only once its whole sample window agrees.
  always_comb begin
    hist_upd  = '0;
    state_nxt = key_state;
    for (int i = 0; i < NKEY; i++) begin
      hist_upd[i] = {hist[i][DS-2:0], sync2[i]};
      if (&hist_upd[i])
        state_nxt[i] = 1'b1;
      else if (~|hist_upd[i])
        state_nxt[i] = 1'b0;
    end
  end

  always_ff @(posedge raw_clk or negedge button_reset) begin
    if (!button_reset) begin
      hist        <= '0;
      key_state   <= '0;
      key_any     <= 1'b0;
      key_changed <= 1'b0;
    end else if (tick) begin
      hist        <= hist_upd;
      key_state   <= state_nxt;
      key_any     <= |state_nxt;
      key_changed <= (state_nxt != key_state);
    end else begin
      key_changed <= 1'b0;
    end
  end

  always_comb begin
    col_k = '0;
    for (int r = 0; r < NR; r++)
      for (int k = 0; k < NK; k++)
        col_k[k] = col_k[k] | (pins_r[r] & key_state[r*NK+k]);
  end

  always_ff @(posedge raw_clk or negedge button_reset) begin
    if (!button_reset) pins_k <= '0;
    else               pins_k <= col_k;
  end

endmodule
